bcd_countdown: RTL and testbench
================================

# bcd_countdown

Three-digit packed-BCD down-counter, the decrementing counterpart to the team's BCD incrementor. Loads a BCD value, counts down one step per qualified `Tick` while running, and pulses `Done` on reaching 000. Used as the countdown timer behind the seven-segment display path. It takes and produces packed BCD in the same 12-bit format as the incrementor: `[11:8]` hundreds, `[7:4]` tens, `[3:0]` units.

## Interface
- No parameters (fixed at 3 digits / 12 bits).
- `Clock  input  1` : sole clock, rising edge.
- `Reset  input  1` : synchronous, active-high; sampled on `Clock` rising edge.
- `Load  input  1` : load `LoadValue` into `Count` (subject to validity check).
- `LoadValue  input  12` : packed BCD value to load.
- `Start  input  1` : enter/resume RUN.
- `Stop  input  1` : pause, return to IDLE, `Count` held.
- `Tick  input  1` : decrement strobe, one step per cycle high while in RUN.
- `Count  output  12` : registered packed BCD count.
- `Running  output  1` : registered, high while in RUN.
- `Done  output  1` : registered one-cycle pulse when `Count` reaches 000 from a decrement.
- `LoadError  output  1` : registered one-cycle pulse when a Load is rejected.

## Operation
- States: IDLE (`Running`=0) and RUN (`Running`=1).
- Per-cycle priority: Reset > Load > Stop > Start > Tick.
- Reset: `Count`=000, IDLE, `Done`=0, `LoadError`=0. Applies in any state, mid-count included.
- Load, in any state:
  - If every nibble of `LoadValue` is ≤ 9: `Count`←`LoadValue`, state←IDLE.
  - If any nibble is > 9: `Count` and state are unchanged, and `LoadError` pulses for 1 cycle.
  - Start, Stop and Tick are ignored in that cycle.
- Stop in RUN: state←IDLE, no decrement that cycle. Stop in IDLE: no effect.
- Start in IDLE:
  - If `Count`≠000: state←RUN. A Tick in the same cycle is not applied.
  - If `Count`=000: ignored, with no `Done` and no error.
  - Start in RUN: no effect.
- Tick in RUN decrements `Count` by 1 in BCD:
  - Units 0→9 with a borrow to tens; tens 0→9 with a borrow to hundreds.
  - Examples: 100→099, 010→009, 001→000.
  - Digit arithmetic is 4-bit, borrow-chained. Digits never leave 0–9.
- Reaching 000 on a Tick: `Done`=1 for exactly that cycle, and state←IDLE automatically.
  - `Count` never underflows below 000.
- Tick in IDLE: ignored.
- `Done` and `LoadError` are 0 in every cycle not listed above.
- `Count` always holds valid BCD after reset.

## Timing
- All outputs are registered. The reset value of every output is 0 (`Count`=12'h000).
- Load: `Count` shows the new value 1 cycle after the edge sampling `Load`=1. `LoadError` is on that same cycle.
- Start: `Running`=1 one cycle after the edge sampling `Start`. The first Tick that can decrement is the one sampled on that following edge.
- Tick: `Count` updates on the edge sampling `Tick`=1 (1-cycle latency).
- Final decrement (001→000): `Done`=1 and `Running`=0 in the same cycle that `Count` first reads 000.
- Back-to-back Ticks decrement every cycle. There is no throughput limit.
- Simultaneous events:
  - Stop+Tick in RUN: no decrement.
  - Load+Start: Load only.
  - Reset with anything: reset only.

## Test plan
- Reset mid-run: load 12'h250, Start, 3 Ticks (`Count`=247), then Reset → `Count`=000, `Running`=0, `Done`=0 next cycle.
- Borrow chain: load 12'h100, Start, 1 Tick → 12'h099. Load 12'h010, Start, 1 Tick → 12'h009.
- Terminal count: load 12'h003, Start, Tick every cycle → 002, 001, 000.
  - `Done`=1 only on the 000 cycle and `Running`=0 there.
  - A further Tick leaves 000 with no second `Done`.
- Invalid load: load 12'h05A while `Count`=12'h123 → `Count` stays 123, `LoadError` pulses 1 cycle. Load 12'hA00 behaves the same.
- Pause/priority:
  - In RUN at 12'h050, assert Stop+Tick together → `Count` stays 050, `Running`=0.
  - Start+Tick together → `Running`=1, `Count` still 050. The next Tick gives 049.
- Start at zero: after reset, Start with no Load → `Running` stays 0 and `Done` stays 0. Full sweep: load 12'h999 and tick to 000 → 999 decrements, every intermediate value is valid BCD, and exactly one `Done`.

Source files
------------

// File: rtl/bcd_countdown.sv
// Three-digit packed-BCD down-counter with load, start/stop control,
// a one-cycle done pulse on reaching 000 and a load-error pulse on bad BCD.
module bcd_countdown (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [11:0] load_value,
  input  logic        start,
  input  logic        stop,
  input  logic        tick,
  output logic [11:0] count,
  output logic        running,
  output logic        done,
  output logic        load_error
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned COUNT_W = 3 * DIGIT_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 load_error_q, load_error_d;

  logic                 load_valid;
  logic [COUNT_W-1:0]   count_dec;

  // A packed value is loadable only if every nibble is a decimal digit.
  function automatic logic bcd_valid(input logic [COUNT_W-1:0] v);
    return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Borrow-chained BCD decrement; only called with a non-zero operand.
  function automatic logic [COUNT_W-1:0] bcd_dec(input logic [COUNT_W-1:0] v);
    logic [DIGIT_W-1:0] units, tens, hundreds;
    logic               borrow_u, borrow_t;
    borrow_u = (v[3:0] == 4'd0);
    units    = borrow_u ? 4'd9 : DIGIT_W'(v[3:0] - 4'd1);
    borrow_t = borrow_u && (v[7:4] == 4'd0);
    if (!borrow_u)      tens = v[7:4];
    else if (borrow_t)  tens = 4'd9;
    else                tens = DIGIT_W'(v[7:4] - 4'd1);
    hundreds = borrow_t ? DIGIT_W'(v[11:8] - 4'd1) : v[11:8];
    return {hundreds, tens, units};
  endfunction

  assign load_valid = bcd_valid(load_value);
  assign count_dec  = bcd_dec(count_q);

  // Register stage: synchronous reset clears state and all outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      running_q    <= running_d;
      done_q       <= done_d;
      load_error_q <= load_error_d;
    end
  end

  // Next-state logic with priority Load > Stop > Start > Tick.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    done_d       = 1'b0;
    load_error_d = 1'b0;

    if (load) begin
      if (load_valid) begin
        count_d = load_value;
        state_d = IDLE;
      end else begin
        load_error_d = 1'b1;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else if (start && (state_q == IDLE)) begin
      if (count_q != '0) state_d = RUN;
    end else if (tick && (state_q == RUN)) begin
      count_d = count_dec;
      if (count_dec == '0) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end

    running_d = (state_d == RUN);
  end

  assign count      = count_q;
  assign running    = running_q;
  assign done       = done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed self-checking bench for bcd_countdown.
module tb_bcd_countdown;

  logic        clock;
  logic        reset;
  logic        load;
  logic [11:0] load_value;
  logic        start;
  logic        stop;
  logic        tick;
  logic [11:0] count;
  logic        running;
  logic        done;
  logic        load_error;

  int errors = 0;
  int checks = 0;

  bcd_countdown dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .tick       (tick),
    .count      (count),
    .running    (running),
    .done       (done),
    .load_error (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic l, input logic [11:0] lv, input logic sa,
                       input logic so, input logic t);
    load = l; load_value = lv; start = sa; stop = so; tick = t;
    @(posedge clock); #1;
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 12'h000) begin errors++; $display("FAIL reset_count: got %h want 000", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL reset_load_error: got %b want 0", load_error); end
    drive(1'b1, 12'h250, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    checks++; if (count !== 12'h247) begin errors++; $display("FAIL midrun_count: got %h want 247", count); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL midrun_running: got %b want 1", running); end
    do_reset();
    checks++; if (count !== 12'h000) begin errors++; $display("FAIL midrun_reset_count: got %h want 000", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrun_reset_running: got %b want 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrun_reset_done: got %b want 0", done); end
  endtask

  task automatic test_borrow();
    drive(1'b1, 12'h100, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    checks++; if (count !== 12'h099) begin errors++; $display("FAIL borrow_100: got %h want 099", count); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL borrow_100_running: got %b want 1", running); end
    drive(1'b1, 12'h010, 1'b0, 1'b0, 1'b0);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL load_in_run_idle: got %b want 0", running); end
    drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    checks++; if (count !== 12'h009) begin errors++; $display("FAIL borrow_010: got %h want 009", count); end
  endtask

  task automatic test_terminal();
    logic [11:0] exp_c [3];
    exp_c[0] = 12'h002; exp_c[1] = 12'h001; exp_c[2] = 12'h000;
    drive(1'b1, 12'h003, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
      checks++; if (count !== exp_c[i]) begin errors++; $display("FAIL term_count[%0d]: got %h want %h", i, count, exp_c[i]); end
      checks++; if (done !== (i == 2)) begin errors++; $display("FAIL term_done[%0d]: got %b want %b", i, done, (i == 2)); end
      checks++; if (running !== (i != 2)) begin errors++; $display("FAIL term_running[%0d]: got %b want %b", i, running, (i != 2)); end
    end
    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    checks++; if (count !== 12'h000) begin errors++; $display("FAIL term_extra_count: got %h want 000", count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL term_extra_done: got %b want 0", done); end
  endtask

  task automatic test_invalid_load();
    drive(1'b1, 12'h123, 1'b0, 1'b0, 1'b0);
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL valid_load_err: got %b want 0", load_error); end
    drive(1'b1, 12'h05A, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 12'h123) begin errors++; $display("FAIL bad05A_count: got %h want 123", count); end
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL bad05A_err: got %b want 1", load_error); end
    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL bad05A_err_pulse: got %b want 0", load_error); end
    drive(1'b1, 12'hA00, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 12'h123) begin errors++; $display("FAIL badA00_count: got %h want 123", count); end
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL badA00_err: got %b want 1", load_error); end
    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL badA00_err_pulse: got %b want 0", load_error); end
  endtask

  task automatic test_pause();
    drive(1'b1, 12'h050, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_run: got %b want 1", running); end
    drive(1'b0, 12'h000, 1'b0, 1'b1, 1'b1);
    checks++; if (count !== 12'h050) begin errors++; $display("FAIL stop_tick_count: got %h want 050", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_tick_running: got %b want 0", running); end
    drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_tick_running: got %b want 1", running); end
    checks++; if (count !== 12'h050) begin errors++; $display("FAIL start_tick_count: got %h want 050", count); end
    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    checks++; if (count !== 12'h049) begin errors++; $display("FAIL resume_tick: got %h want 049", count); end
    drive(1'b1, 12'h777, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 12'h777) begin errors++; $display("FAIL load_start_count: got %h want 777", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL load_start_running: got %b want 0", running); end
  endtask

  task automatic test_start_zero();
    do_reset();
    drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL zero_start_running: got %b want 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_start_done: got %b want 0", done); end
    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    checks++; if (count !== 12'h000) begin errors++; $display("FAIL idle_tick_count: got %h want 000", count); end
  endtask

  task automatic test_sweep();
    int n_done;
    int n_bad;
    n_done = 0;
    n_bad  = 0;
    drive(1'b1, 12'h999, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 999; i++) begin
      drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
      if (done === 1'b1) n_done++;
      if (count !== to_bcd(999 - i) || done !== (i == 999)) begin
        n_bad++;
        if (n_bad <= 5) $display("FAIL sweep_step[%0d]: got %h done=%b want %h done=%b",
                                 i, count, done, to_bcd(999 - i), (i == 999));
      end
    end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL sweep_values: got %0d bad steps want 0", n_bad); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL sweep_done_count: got %0d want 1", n_done); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL sweep_end_running: got %b want 0", running); end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_value = 12'h000;
    start = 1'b0; stop = 1'b0; tick = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_borrow();
    test_terminal();
    test_invalid_load();
    test_pause();
    test_start_zero();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
